// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 sets of 256-bit lines,
// 32-bit byte-enabled CPU port, whole-line fills and writebacks on the memory port.
module cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NUM_SETS = 1 << s_index;
  localparam int WORD_W   = s_offset - 2;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t              r_state;
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [s_tag-1:0]    r_tag  [NUM_SETS];
  logic [255:0]        r_data [NUM_SETS];

  logic [s_index-1:0]  w_index;
  logic [s_tag-1:0]    w_tag;
  logic [WORD_W-1:0]   w_word;
  logic [255:0]        w_line;
  logic [255:0]        w_merged;
  logic [31:0]         w_rword;
  logic                w_hit;
  logic                w_req;
  logic                w_we;
  logic                w_unused;

  assign w_index  = mem_address[s_offset +: s_index];
  assign w_tag    = mem_address[31 -: s_tag];
  assign w_word   = mem_address[s_offset-1:2];
  assign w_line   = r_data[w_index];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_req    = mem_read | mem_write;
  assign w_we     = mem_write;
  assign w_rword  = w_line[int'(w_word)*32 +: 32];
  assign w_unused = ^mem_address[1:0];

  // Byte-strobed merge of the CPU write into the selected word of the line.
  always_comb begin
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        w_merged[int'(w_word)*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (w_we) begin
                r_dirty[w_index] <= 1'b1;
              end else begin
                mem_rdata <= w_rword;
              end
              mem_resp <= 1'b1;
              r_state  <= S_RESP;
            end else if (r_valid[w_index] && r_dirty[w_index]) begin
              pmem_write   <= 1'b1;
              pmem_address <= {r_tag[w_index], w_index, {s_offset{1'b0}}};
              r_state      <= S_WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {mem_address[31:s_offset], {s_offset{1'b0}}};
              r_state      <= S_ALLOCATE;
            end
          end
        end
        S_RESP: r_state <= S_IDLE;
        S_WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write       <= 1'b0;
            r_dirty[w_index] <= 1'b0;
            pmem_read        <= 1'b1;
            pmem_address     <= {mem_address[31:s_offset], {s_offset{1'b0}}};
            r_state          <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          // The request is still held, so IDLE re-evaluates it as a hit next cycle.
          if (pmem_resp) begin
            pmem_read        <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays and the victim buffer carry no reset; a reset state of IDLE
  // with all sets invalid keeps them from being used before being refilled.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req && w_hit && w_we) begin
      r_data[w_index] <= w_merged;
    end
    if (r_state == S_IDLE && w_req && !w_hit) begin
      pmem_wdata <= w_line;
    end
    if (r_state == S_ALLOCATE && pmem_resp) begin
      r_data[w_index] <= pmem_rdata;
      r_tag[w_index]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Randomized and directed bench for the cache, checked against a line-level shadow
// memory and a per-set valid/dirty/tag model of a direct-mapped write-back cache.
module tb_cache;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] PRELOAD =
    256'h13030303_00c0ffee_deadbeef_01234567_89abcdef_55aa55aa_0f0f0f0f_47591908;

  int total = 0;
  int bad   = 0;
  int nrd = 0, nwr = 0, nresp = 0, ntrans = 0;
  logic [31:0]  last_rd_addr, last_wb_addr;
  logic [255:0] last_wb_data;
  bit hold_resp = 1'b0;

  logic [255:0] gold [logic [26:0]];
  logic [255:0] bmem [logic [26:0]];
  bit          mv [8];
  bit          md [8];
  logic [23:0] mt [8];

  function automatic logic [255:0] init_line(input logic [26:0] ln);
    logic [255:0] l;
    if (ln == 27'd0) return PRELOAD;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {ln, w[2:0], 2'b00} ^ 32'hC3A50F1E;
    return l;
  endfunction

  function automatic logic [255:0] gold_line(input logic [26:0] ln);
    return gold.exists(ln) ? gold[ln] : init_line(ln);
  endfunction

  function automatic logic [255:0] bmem_line(input logic [26:0] ln);
    return bmem.exists(ln) ? bmem[ln] : init_line(ln);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory-side responder: random delay, then a one-cycle pmem_resp.
  initial begin
    logic [26:0] ln;
    int d;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if ((pmem_read || pmem_write) && !hold_resp && !rst) begin
        d = $urandom_range(0, 3);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        if (hold_resp || rst) continue;
        ln = pmem_address[31:5];
        if (pmem_write) begin
          chk("wb_line_matches_shadow", pmem_wdata, gold_line(ln));
          bmem[ln]     = pmem_wdata;
          last_wb_addr = pmem_address;
          last_wb_data = pmem_wdata;
          nwr++;
        end else if (pmem_read) begin
          pmem_rdata   = bmem_line(ln);
          last_rd_addr = pmem_address;
          nrd++;
        end else begin
          continue;
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_resp) nresp++;
    chk("pmem_strobes_exclusive", {255'd0, pmem_read & pmem_write}, 256'd0);
  end

  task automatic access(input bit we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd);
    logic [26:0]  ln;
    logic [23:0]  tg;
    logic [255:0] gl;
    logic [31:0]  ew;
    int idx, wi, r0, w0, n;
    bit hit, ewb;
    ln  = a[31:5];
    tg  = a[31:8];
    idx = int'(a[7:5]);
    wi  = int'(a[4:2]);
    r0  = nrd;
    w0  = nwr;
    hit = mv[idx] && (mt[idx] == tg);
    ewb = !hit && mv[idx] && md[idx];
    gl  = gold_line(ln);
    ew  = gl[wi*32 +: 32];
    mem_address     = a;
    mem_read        = !we;
    mem_write       = we;
    mem_byte_enable = be;
    mem_wdata       = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_resp && n < 300);
    ntrans++;
    chk("resp_seen", {255'd0, mem_resp}, 256'd1);
    rd = mem_rdata;
    if (!we) chk("rdata_vs_shadow", mem_rdata, ew);
    chk("writeback_count", nwr - w0, ewb ? 1 : 0);
    chk("fill_count", nrd - r0, hit ? 0 : 1);
    if (ewb) chk("writeback_addr", last_wb_addr, {mt[idx], idx[2:0], 5'b0});
    if (!hit) chk("fill_addr", last_rd_addr, {a[31:5], 5'b0});
    if (hit) chk("hit_latency_le2", {255'd0, n <= 2}, 256'd1);
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) gl[wi*32 + b*8 +: 8] = wd[b*8 +: 8];
      gold[ln] = gl;
    end
    md[idx] = (hit && md[idx]) || we;
    mv[idx] = 1'b1;
    mt[idx] = tg;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_resp"}, {255'd0, mem_resp}, 256'd0);
    chk({tag, "_pmem_read"}, {255'd0, pmem_read}, 256'd0);
    chk({tag, "_pmem_write"}, {255'd0, pmem_write}, 256'd0);
    chk({tag, "_pmem_address"}, pmem_address, 256'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 256'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [23:0] tags [4];
    int n;
    tags[0] = 24'h000000; tags[1] = 24'h00091A; tags[2] = 24'h004321; tags[3] = 24'h0000FF;
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
    rst = 1'b1; mem_address = '0; mem_read = 0; mem_write = 0;
    mem_byte_enable = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    access(0, 32'h00000000, 4'hF, 32'h0, rd);
    chk("cold_read_addr0", rd, 32'h47591908);

    access(0, 32'h00091A21, 4'hF, 32'h0, rd);
    access(1, 32'h00091A41, 4'hF, 32'haabbccdd, rd);
    access(0, 32'h00091A41, 4'hF, 32'h0, rd);
    chk("read_after_write", rd, 32'haabbccdd);

    access(0, 32'h00432142, 4'hF, 32'h0, rd);
    chk("conflict_wb_word0", last_wb_data[31:0], 32'haabbccdd);
    access(0, 32'h00091A41, 4'hF, 32'h0, rd);
    chk("refetched_word", rd, 32'haabbccdd);

    access(1, 32'h00091A44, 4'hF, 32'h12345678, rd);
    access(1, 32'h00091A48, 4'hF, 32'hcafef00d, rd);
    access(0, 32'h00432140, 4'hF, 32'h0, rd);
    chk("wb_word1_last_data", last_wb_data[63:32], 32'h12345678);
    chk("wb_word2_last_data", last_wb_data[95:64], 32'hcafef00d);

    access(1, 32'h00091A60, 4'hF, 32'h11223344, rd);
    access(1, 32'h00091A60, 4'hC, 32'haabbccdd, rd);
    access(0, 32'h00091A60, 4'hF, 32'h0, rd);
    chk("partial_mbe_1100", rd, 32'haabb3344);
    access(1, 32'h00091A60, 4'h3, 32'hbbccddee, rd);
    access(0, 32'h00091A60, 4'hF, 32'h0, rd);
    chk("partial_mbe_0011", rd, 32'haabbddee);
    idle();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      access(bit'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, rd);
    end
    idle();

    access(0, 32'h0000FF00, 4'hF, 32'h0, rd);
    idle();
    hold_resp = 1'b1;
    mem_address = 32'h00000100;
    mem_read    = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pmem_read && n < 20);
    chk("alloc_pmem_read", {255'd0, pmem_read}, 256'd1);
    chk("alloc_pmem_addr", pmem_address, 32'h00000100);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midalloc_reset");
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hold_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
    gold = bmem;
    @(posedge clk); #1;
    access(0, 32'h0000FF00, 4'hF, 32'h0, rd);
    access(0, 32'h00000104, 4'hF, 32'h0, rd);
    idle();

    chk("resp_pulse_total", nresp, ntrans);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
